// File: rtl/fill_sequencer_pkg.sv
// Shared definitions for the tablet filling machine controller.
// Contents:
//   DEF_*      default widths, legal maxima and conveyor change time
//   state_e    sequencer state encoding, also shown on the front panel
package fill_pkg;

   localparam int unsigned DEF_TAB_W         = 8;
   localparam int unsigned DEF_BOT_W         = 16;
   localparam int unsigned DEF_MAX_TABLETS   = 99;
   localparam int unsigned DEF_MAX_BOTTLES   = 9999;
   localparam int unsigned DEF_CHANGE_CYCLES = 4;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_BOTTLE = 3'd1,
      ST_FILLING     = 3'd2,
      ST_BOTTLE_DONE = 3'd3,
      ST_CHANGE      = 3'd4,
      ST_BATCH_DONE  = 3'd5,
      ST_FAULT       = 3'd6
   } state_e;

endpackage

// File: rtl/fill_sequencer_if.sv
// Operator/machine signal bundle of the filling sequencer.
// Ports of the master (operator panel / machine side) modport:
//   start, clear, pause, tablets_per_bottle, bottles_per_batch,
//   tablet_pulse, bottle_in_place                      -> driven
//   valve_open, conveyor_run, tablet_count, bottle_count,
//   state, batch_done, cfg_error, fault                -> observed
// The slave modport (sequencer side) has the opposite directions.
interface fill_sequencer_if
   import fill_pkg::*;
#(
   parameter int unsigned TAB_W = DEF_TAB_W,
   parameter int unsigned BOT_W = DEF_BOT_W
) ();

   logic             start;
   logic             clear;
   logic             pause;
   logic [TAB_W-1:0] tablets_per_bottle;
   logic [BOT_W-1:0] bottles_per_batch;
   logic             tablet_pulse;
   logic             bottle_in_place;

   logic             valve_open;
   logic             conveyor_run;
   logic [TAB_W-1:0] tablet_count;
   logic [BOT_W-1:0] bottle_count;
   logic [2:0]       state;
   logic             batch_done;
   logic             cfg_error;
   logic             fault;

   modport master (
      output start, clear, pause, tablets_per_bottle, bottles_per_batch,
             tablet_pulse, bottle_in_place,
      input  valve_open, conveyor_run, tablet_count, bottle_count,
             state, batch_done, cfg_error, fault
   );

   modport slave (
      input  start, clear, pause, tablets_per_bottle, bottles_per_batch,
             tablet_pulse, bottle_in_place,
      output valve_open, conveyor_run, tablet_count, bottle_count,
             state, batch_done, cfg_error, fault
   );

endinterface

// File: rtl/fill_sequencer_target_counter.sv
// Loadable up-counter with a latched target.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-low reset
//   i_load       latch i_target and zero the count
//   i_target     target value sampled on i_load
//   i_clr        zero the count, target kept
//   i_en         increment the count
//   o_count      current count
//   o_at_last    registered flag, high while count == target-1
// Priority: i_load > i_clr > i_en.
module target_counter
   import fill_pkg::*;
#(
   parameter int unsigned W = DEF_TAB_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_target,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_at_last
);

   logic [W-1:0] r_target;
   logic [W-1:0] r_count;
   logic         r_at_last;
   logic [W-1:0] w_target_nx;
   logic [W-1:0] w_count_nx;

   always_comb begin
      w_target_nx = r_target;
      w_count_nx  = r_count;
      if (i_load) begin
         w_target_nx = i_target;
         w_count_nx  = '0;
      end else if (i_clr) begin
         w_count_nx = '0;
      end else if (i_en) begin
         w_count_nx = r_count + W'(1);
      end
   end

   // at_last is derived from the next count/target so it is valid in
   // the same cycle the count register shows the new value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_target  <= '0;
         r_count   <= '0;
         r_at_last <= 1'b0;
      end else begin
         r_target  <= w_target_nx;
         r_count   <= w_count_nx;
         r_at_last <= (w_target_nx != '0) && (w_count_nx == w_target_nx - W'(1));
      end
   end

   assign o_count   = r_count;
   assign o_at_last = r_at_last;

endmodule

// File: rtl/fill_sequencer.sv
// Batch sequencer for the tablet filling machine: indexes a bottle in,
// fills it to the per-bottle tablet target, moves it out, and repeats
// until the per-batch bottle target is met.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset, overrides everything
//   bus    fill_sequencer_if.slave: commands, targets, sensors in;
//          valve/conveyor drives, counts, state and flags out
// All outputs are registered; the drives are decoded from the next state.
module fill_sequencer
   import fill_pkg::*;
#(
   parameter int unsigned TAB_W         = DEF_TAB_W,
   parameter int unsigned BOT_W         = DEF_BOT_W,
   parameter int unsigned MAX_TABLETS   = DEF_MAX_TABLETS,
   parameter int unsigned MAX_BOTTLES   = DEF_MAX_BOTTLES,
   parameter int unsigned CHANGE_CYCLES = DEF_CHANGE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   fill_sequencer_if.slave  bus
);

   state_e       r_state;
   logic [7:0]   r_timer;
   logic         r_valve_open;
   logic         r_conveyor_run;
   logic         r_batch_done;
   logic         r_cfg_error;
   logic         r_fault;

   state_e       w_next_state;
   logic [7:0]   w_timer_nx;
   logic         w_valve_nx;
   logic         w_conv_nx;
   logic         w_done_nx;
   logic         w_cfg_nx;
   logic         w_fault_nx;
   logic         w_load;
   logic         w_clr_all;
   logic         w_wait_entry;
   logic         w_tab_en;
   logic         w_bot_en;
   logic         w_tab_last;
   logic         w_bot_last;
   logic         w_cfg_ok;
   logic [TAB_W-1:0] w_tab_count;
   logic [BOT_W-1:0] w_bot_count;

   assign w_cfg_ok = (bus.tablets_per_bottle != '0)
                  && (32'(bus.tablets_per_bottle) <= MAX_TABLETS)
                  && (bus.bottles_per_batch != '0)
                  && (32'(bus.bottles_per_batch) <= MAX_BOTTLES);

   target_counter #(.W(TAB_W)) u_tab_cnt (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_target  (bus.tablets_per_bottle),
      .i_clr     (w_clr_all | w_wait_entry),
      .i_en      (w_tab_en),
      .o_count   (w_tab_count),
      .o_at_last (w_tab_last)
   );

   target_counter #(.W(BOT_W)) u_bot_cnt (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_target  (bus.bottles_per_batch),
      .i_clr     (w_clr_all),
      .i_en      (w_bot_en),
      .o_count   (w_bot_count),
      .o_at_last (w_bot_last)
   );

   always_comb begin
      w_next_state = r_state;
      w_timer_nx   = r_timer;
      w_done_nx    = r_batch_done;
      w_cfg_nx     = r_cfg_error;
      w_fault_nx   = r_fault;
      w_load       = 1'b0;
      w_clr_all    = 1'b0;
      w_tab_en     = 1'b0;
      w_bot_en     = 1'b0;

      if (bus.clear) begin
         w_next_state = ST_IDLE;
         w_timer_nx   = '0;
         w_done_nx    = 1'b0;
         w_cfg_nx     = 1'b0;
         w_fault_nx   = 1'b0;
         w_clr_all    = 1'b0 | 1'b1;
      end else begin
         // Tablets already in the chute still land while paused, so the
         // count (and bottle completion) is evaluated outside the pause gate.
         if ((r_state == ST_FILLING) && bus.tablet_pulse) begin
            w_tab_en = 1'b1;
            if (w_tab_last) w_next_state = ST_BOTTLE_DONE;
         end

         if (!bus.pause) begin
            case (r_state)
               ST_IDLE, ST_BATCH_DONE: begin
                  if (bus.start) begin
                     w_done_nx = 1'b0;
                     if (w_cfg_ok) begin
                        w_load       = 1'b1;
                        w_cfg_nx     = 1'b0;
                        w_next_state = ST_WAIT_BOTTLE;
                     end else begin
                        w_cfg_nx = 1'b1;
                     end
                  end
               end
               ST_WAIT_BOTTLE: begin
                  if (bus.bottle_in_place) w_next_state = ST_FILLING;
               end
               ST_FILLING: begin
                  // Bottle loss wins over a completing pulse in the same cycle.
                  if (!bus.bottle_in_place) w_next_state = ST_FAULT;
               end
               ST_BOTTLE_DONE: begin
                  w_bot_en = 1'b1;
                  if (w_bot_last) begin
                     w_next_state = ST_BATCH_DONE;
                     w_done_nx    = 1'b1;
                  end else begin
                     w_next_state = ST_CHANGE;
                     w_timer_nx   = 8'(CHANGE_CYCLES);
                  end
               end
               ST_CHANGE: begin
                  if (r_timer <= 8'd1) w_next_state = ST_WAIT_BOTTLE;
                  else                 w_timer_nx   = r_timer - 8'd1;
               end
               ST_FAULT: ;
               default: w_next_state = ST_IDLE;
            endcase
         end

         if (w_next_state == ST_FAULT) w_fault_nx = 1'b1;
      end

      w_wait_entry = (w_next_state == ST_WAIT_BOTTLE) && (r_state != ST_WAIT_BOTTLE);
      w_valve_nx   = !bus.pause && (w_next_state == ST_FILLING);
      w_conv_nx    = !bus.pause && ((w_next_state == ST_WAIT_BOTTLE) ||
                                    (w_next_state == ST_CHANGE));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_timer        <= '0;
         r_valve_open   <= 1'b0;
         r_conveyor_run <= 1'b0;
         r_batch_done   <= 1'b0;
         r_cfg_error    <= 1'b0;
         r_fault        <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_timer        <= w_timer_nx;
         r_valve_open   <= w_valve_nx;
         r_conveyor_run <= w_conv_nx;
         r_batch_done   <= w_done_nx;
         r_cfg_error    <= w_cfg_nx;
         r_fault        <= w_fault_nx;
      end
   end

   assign bus.valve_open   = r_valve_open;
   assign bus.conveyor_run = r_conveyor_run;
   assign bus.tablet_count = w_tab_count;
   assign bus.bottle_count = w_bot_count;
   assign bus.state        = r_state;
   assign bus.batch_done   = r_batch_done;
   assign bus.cfg_error    = r_cfg_error;
   assign bus.fault        = r_fault;

endmodule

// File: tb/tb_fill_sequencer.sv
// Self-checking bench for fill_sequencer: directed vector table,
// hand-written multi-cycle sequences and a randomized run, all checked
// against a behavioural model of the batch rules.
module tb_fill_sequencer;

   localparam int unsigned TW   = 8;
   localparam int unsigned BW   = 16;
   localparam int unsigned MAXT = 99;
   localparam int unsigned MAXB = 9999;
   localparam int unsigned CC   = 4;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   fill_sequencer_if #(.TAB_W(TW), .BOT_W(BW)) bus ();

   fill_sequencer #(
      .TAB_W(TW), .BOT_W(BW), .MAX_TABLETS(MAXT),
      .MAX_BOTTLES(MAXB), .CHANGE_CYCLES(CC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_state, m_tc, m_bc, m_tt, m_bt, m_timer;
   bit m_valve, m_conv, m_done, m_cfg, m_fault;

   task automatic model_step();
      int ns;
      int t;
      int b;
      if (!reset) begin
         m_state = 0; m_tc = 0; m_bc = 0; m_tt = 0; m_bt = 0; m_timer = 0;
         m_valve = 0; m_conv = 0; m_done = 0; m_cfg = 0; m_fault = 0;
         return;
      end
      if (bus.clear) begin
         m_state = 0; m_tc = 0; m_bc = 0; m_timer = 0;
         m_valve = 0; m_conv = 0; m_done = 0; m_cfg = 0; m_fault = 0;
         return;
      end
      ns = m_state;
      if (m_state == 2 && bus.tablet_pulse) begin
         m_tc = m_tc + 1;
         if (m_tc == m_tt) ns = 3;
      end
      if (!bus.pause) begin
         case (m_state)
            0, 5: if (bus.start) begin
               t = int'(bus.tablets_per_bottle);
               b = int'(bus.bottles_per_batch);
               m_done = 0;
               if (t >= 1 && t <= int'(MAXT) && b >= 1 && b <= int'(MAXB)) begin
                  m_tt = t; m_bt = b; m_tc = 0; m_bc = 0; m_cfg = 0; ns = 1;
               end else begin
                  m_cfg = 1;
               end
            end
            1: if (bus.bottle_in_place) ns = 2;
            2: if (!bus.bottle_in_place) ns = 6;
            3: begin
               m_bc = m_bc + 1;
               if (m_bc == m_bt) begin ns = 5; m_done = 1; end
               else begin ns = 4; m_timer = int'(CC); end
            end
            4: if (m_timer == 1) ns = 1; else m_timer = m_timer - 1;
            default: ;
         endcase
      end
      if (ns == 6) m_fault = 1;
      if (ns == 1 && m_state != 1) m_tc = 0;
      m_valve = !bus.pause && (ns == 2);
      m_conv  = !bus.pause && (ns == 1 || ns == 4);
      m_state = ns;
   endtask

   function automatic logic [31:0] dut_vec();
      return {bus.state, bus.valve_open, bus.conveyor_run, bus.tablet_count,
              bus.bottle_count, bus.batch_done, bus.cfg_error, bus.fault};
   endfunction

   function automatic logic [31:0] model_vec();
      return {3'(m_state), m_valve, m_conv, 8'(m_tc), 16'(m_bc), m_done, m_cfg, m_fault};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("model", dut_vec(), model_vec());
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic rst, st, clr, pau;
      logic [7:0] tpb;
      logic [15:0] bpb;
      logic pul, bip;
      logic [2:0] e_state;
      logic e_valve, e_conv;
      logic [7:0] e_tc;
      logic [15:0] e_bc;
      logic e_done, e_cfg, e_fault;
   } vec_t;

   vec_t tbl[22];

   function automatic logic [31:0] exp_vec(input vec_t v);
      return {v.e_state, v.e_valve, v.e_conv, v.e_tc, v.e_bc, v.e_done, v.e_cfg, v.e_fault};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int r;
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bus.start = 0; bus.clear = 0; bus.pause = 0;
      bus.tablets_per_bottle = '0; bus.bottles_per_batch = '0;
      bus.tablet_pulse = 0; bus.bottle_in_place = 0;

      //            rst st clr pau tpb  bpb    pul bip  st v c tc bc dn cfg flt
      tbl[0]  = '{0,0,0,0,   0,    0, 0,0,  0,0,0, 0,0, 0,0,0};
      tbl[1]  = '{1,1,0,0,   0,    1, 0,0,  0,0,0, 0,0, 0,1,0};
      tbl[2]  = '{1,0,0,0,   0,    1, 0,0,  0,0,0, 0,0, 0,1,0};
      tbl[3]  = '{1,1,0,0,   5,    1, 0,0,  1,0,1, 0,0, 0,0,0};
      tbl[4]  = '{1,0,0,0,   5,    1, 0,1,  2,1,0, 0,0, 0,0,0};
      tbl[5]  = '{1,0,0,0,   5,    1, 1,1,  2,1,0, 1,0, 0,0,0};
      tbl[6]  = '{1,0,0,0,   5,    1, 0,0,  6,0,0, 1,0, 0,0,1};
      tbl[7]  = '{1,1,0,0,   5,    1, 0,0,  6,0,0, 1,0, 0,0,1};
      tbl[8]  = '{1,0,1,0,   5,    1, 0,0,  0,0,0, 0,0, 0,0,0};
      tbl[9]  = '{1,1,0,0, 100,    1, 0,0,  0,0,0, 0,0, 0,1,0};
      tbl[10] = '{1,1,0,0,   1,10000, 0,0,  0,0,0, 0,0, 0,1,0};
      tbl[11] = '{1,1,0,0,  99, 9999, 0,0,  1,0,1, 0,0, 0,0,0};
      tbl[12] = '{1,0,0,0,  99, 9999, 0,1,  2,1,0, 0,0, 0,0,0};
      tbl[13] = '{0,0,0,0,  99, 9999, 1,1,  0,0,0, 0,0, 0,0,0};
      tbl[14] = '{1,1,0,0,   1,    1, 0,0,  1,0,1, 0,0, 0,0,0};
      tbl[15] = '{1,0,0,0,   1,    1, 1,1,  2,1,0, 0,0, 0,0,0};
      tbl[16] = '{1,0,0,0,   1,    1, 1,1,  3,0,0, 1,0, 0,0,0};
      tbl[17] = '{1,0,0,0,   1,    1, 0,1,  5,0,0, 1,1, 1,0,0};
      tbl[18] = '{1,0,0,0,   1,    1, 1,1,  5,0,0, 1,1, 1,0,0};
      tbl[19] = '{1,1,0,0,   0,    1, 0,1,  5,0,0, 1,1, 0,1,0};
      tbl[20] = '{1,1,0,0,   2,    1, 0,1,  1,0,1, 0,0, 0,0,0};
      tbl[21] = '{1,0,1,0,   2,    1, 0,1,  0,0,0, 0,0, 0,0,0};

      for (int i = 0; i < 22; i++) begin
         reset                  = tbl[i].rst;
         bus.start              = tbl[i].st;
         bus.clear              = tbl[i].clr;
         bus.pause              = tbl[i].pau;
         bus.tablets_per_bottle = tbl[i].tpb;
         bus.bottles_per_batch  = tbl[i].bpb;
         bus.tablet_pulse       = tbl[i].pul;
         bus.bottle_in_place    = tbl[i].bip;
         cyc();
         chk($sformatf("row%0d", i), dut_vec(), exp_vec(tbl[i]));
      end
      reset = 1; bus.start = 0; bus.clear = 0; bus.pause = 0;
      bus.tablet_pulse = 0; bus.bottle_in_place = 0;

      // ---- basic batch: 3 tablets x 2 bottles ----
      bus.clear = 1; cyc(); bus.clear = 0;
      bus.tablets_per_bottle = 3; bus.bottles_per_batch = 2; bus.start = 1;
      cyc(); bus.start = 0;
      chk("basic_wait", 32'(bus.state), 32'd1);
      for (int b = 0; b < 2; b++) begin
         bus.bottle_in_place = 0;
         cyc(); cyc();
         chk("basic_conv", 32'(bus.conveyor_run), 32'd1);
         bus.bottle_in_place = 1;
         cyc();
         chk("basic_fill", 32'({bus.state, bus.valve_open}), 32'({3'd2, 1'b1}));
         for (int p = 0; p < 3; p++) begin
            bus.tablet_pulse = 1; cyc(); bus.tablet_pulse = 0;
            if (p < 2) chk("basic_pulse", 32'({bus.valve_open, bus.tablet_count}), 32'({1'b1, 8'(p + 1)}));
            else       chk("basic_last", 32'({bus.state, bus.valve_open, bus.tablet_count}), 32'({3'd3, 1'b0, 8'd3}));
         end
         cyc();
         if (b == 0) begin
            chk("basic_change", 32'({bus.state, bus.bottle_count}), 32'({3'd4, 16'd1}));
            bus.bottle_in_place = 0;
            repeat (4) cyc();
            chk("basic_rewait", 32'(bus.state), 32'd1);
         end else begin
            chk("basic_done", 32'({bus.state, bus.batch_done, bus.bottle_count, bus.tablet_count}),
                32'({3'd5, 1'b1, 16'd2, 8'd3}));
         end
      end

      // ---- pause mid-fill: 5 tablets, pause at 2 with one pulse inside ----
      bus.clear = 1; cyc(); bus.clear = 0;
      bus.tablets_per_bottle = 5; bus.bottles_per_batch = 1; bus.start = 1;
      cyc(); bus.start = 0;
      bus.bottle_in_place = 1; cyc();
      bus.tablet_pulse = 1; cyc(); cyc(); bus.tablet_pulse = 0;
      chk("pause_pre", 32'(bus.tablet_count), 32'd2);
      bus.pause = 1;
      for (int i = 0; i < 10; i++) begin
         bus.tablet_pulse = (i == 4);
         cyc();
         chk("pause_valve", 32'({bus.state, bus.valve_open}), 32'({3'd2, 1'b0}));
      end
      bus.tablet_pulse = 0;
      chk("pause_count", 32'(bus.tablet_count), 32'd3);
      bus.pause = 0; cyc();
      chk("pause_release", 32'({bus.state, bus.valve_open, bus.tablet_count}), 32'({3'd2, 1'b1, 8'd3}));

      // ---- change timing: conveyor held exactly CC cycles ----
      bus.clear = 1; cyc(); bus.clear = 0;
      bus.tablets_per_bottle = 1; bus.bottles_per_batch = 2; bus.start = 1;
      cyc(); bus.start = 0;
      bus.bottle_in_place = 1; cyc();
      bus.tablet_pulse = 1; cyc(); bus.tablet_pulse = 0;
      cyc();
      chk("change_entry", 32'(bus.state), 32'd4);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.state == 3'd4 && bus.conveyor_run) n++;
         else break;
         cyc();
      end
      chk("change_len", 32'(n), 32'(CC));
      chk("change_exit", 32'({bus.state, bus.conveyor_run, bus.tablet_count}), 32'({3'd1, 1'b1, 8'd0}));

      // ---- randomized run against the model ----
      bus.clear = 1; cyc(); bus.clear = 0;
      for (int k = 0; k < 2500; k++) begin
         reset     = ($urandom_range(0, 299) != 0);
         bus.clear = ($urandom_range(0, 49) == 0);
         bus.pause = ($urandom_range(0, 9) == 0);
         bus.start = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 5);
         bus.tablets_per_bottle = (r == 5) ? 8'd100 : 8'(r);
         r = $urandom_range(0, 4);
         bus.bottles_per_batch = (r == 4) ? 16'd10000 : 16'(r);
         bus.tablet_pulse    = $urandom_range(0, 1);
         bus.bottle_in_place = ($urandom_range(0, 24) != 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
